// File: rtl/fifo_arb_pkg.sv
// Shared FSM state type and round-robin pick helper for the FIFO write arbiter.
// Pure combinational helpers, no latency; no flow control here.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;
  localparam int unsigned RR_POS_W   = 6;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... modulo num_req.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int unsigned           num_req);
    rr_pick_t            res;
    logic [RR_POS_W-1:0] pos;
    res = '0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      pos = {1'b0, ptr} + RR_POS_W'(i);
      if (pos >= RR_POS_W'(num_req)) pos = pos - RR_POS_W'(num_req);
      if (i < num_req && !res.found && valid[pos[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder: first valid requester at or after ptr.
// Purely combinational; no flow control.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int GW     = 2
) (
  input  logic [NumReq-1:0] valid,
  input  logic [GW-1:0]     ptr,
  output logic              found,
  output logic [GW-1:0]     idx
);

  rr_pick_t pick;
  logic     unused_pick_bits;

  always_comb begin
    pick  = rr_pick(RR_MAX_REQ'(valid), RR_IDX_W'(ptr), NumReq);
    found = pick.found;
    idx   = GW'(pick.idx);
  end

  assign unused_pick_bits = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; FIFO_ARB_PKT_LOCK_EN holds grants to packet end.
// Latency: one idle arbitration cycle per grant, then data flows combinationally from the granted requester.
// Backpressure: fifo_wready_i low holds the grant and stalls only the granted requester; others see ready 0.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NumReq    = 4,
  parameter  int DataWidth = 8,
  parameter  int MaxBurst  = 4,
  localparam int GW        = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CW        = $clog2(MaxBurst + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_last_i,
  output logic                        fifo_wvalid_o,
  input  logic                        fifo_wready_i,
  output logic [DataWidth-1:0]        fifo_data_o,
  output logic [NumReq-1:0]           grant_o,
  output logic [GW-1:0]               grant_id_o,
  output logic                        busy_o
);

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]  gnt_id_q, gnt_id_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           pick_found;
  logic [GW-1:0]  pick_idx;
  logic           active;
  logic           beat;
  logic           release_gnt;

  fifo_arb_rr_pick #(
    .NumReq (NumReq),
    .GW     (GW)
  ) u_rr_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Outputs are forced quiet while reset_i is high so no beat can slip through a reset cycle.
  always_comb begin
    active        = (state_q == ARB_GRANT) && !reset_i;
    req_ready_o   = '0;
    grant_o       = '0;
    fifo_wvalid_o = 1'b0;
    fifo_data_o   = '0;
    grant_id_o    = '0;
    if (active) begin
      req_ready_o[gnt_id_q] = fifo_wready_i;
      grant_o[gnt_id_q]     = 1'b1;
      fifo_wvalid_o         = req_valid_i[gnt_id_q];
      fifo_data_o           = req_data_i[int'(gnt_id_q)*DataWidth +: DataWidth];
      grant_id_o            = gnt_id_q;
    end
    busy_o = active;
    beat   = fifo_wvalid_o & fifo_wready_i;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    beat_cnt_d  = beat_cnt_q;
    release_gnt = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (pick_found) begin
        state_d    = ARB_GRANT;
        gnt_id_d   = pick_idx;
        beat_cnt_d = '0;
      end
    end else begin
`ifdef FIFO_ARB_PKT_LOCK_EN
      release_gnt = beat && req_last_i[gnt_id_q];
      if (beat && beat_cnt_q != CW'(MaxBurst)) beat_cnt_d = beat_cnt_q + CW'(1);
`else
      release_gnt = (beat && beat_cnt_q == CW'(MaxBurst - 1)) || !req_valid_i[gnt_id_q];
      if (beat) beat_cnt_d = beat_cnt_q + CW'(1);
`endif
      if (release_gnt) begin
        state_d    = ARB_IDLE;
        beat_cnt_d = '0;
        rr_ptr_d   = (gnt_id_q == GW'(NumReq - 1)) ? '0 : gnt_id_q + GW'(1);
      end
    end
  end

`ifndef FIFO_ARB_PKT_LOCK_EN
  logic unused_last;
  assign unused_last = ^req_last_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester source queues, expected FIFO beats in a scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int GW = 2;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_last_i;
  logic             fifo_wvalid_o;
  logic             fifo_wready_i;
  logic [DW-1:0]    fifo_data_o;
  logic [NR-1:0]    grant_o;
  logic [GW-1:0]    grant_id_o;
  logic             busy_o;

  fifo_wr_arbiter #(.NumReq(NR), .DataWidth(DW), .MaxBurst(MB)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_data_i    (req_data_i),
    .req_last_i    (req_last_i),
    .fifo_wvalid_o (fifo_wvalid_o),
    .fifo_wready_i (fifo_wready_i),
    .fifo_data_o   (fifo_data_o),
    .grant_o       (grant_o),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int              n_pass = 0;
  int              n_chk  = 0;
  int              cyc    = 0;
  logic [8:0]      src_q[NR][$];
  logic [GW+DW-1:0] exp_q[$];
  int              bc_q[$];
  logic [NR-1:0]   hs_r = '0;
  logic [GW+DW-1:0] mon_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every FIFO beat is matched against the scoreboard head.
  always @(negedge clk_i) begin
    hs_r <= req_valid_i & req_ready_o;
    if (fifo_wvalid_o && fifo_wready_i) begin
      bc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL beat_extra: got id %0d data 0x%0h, expected no beat", grant_id_o, fifo_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_id_data", {22'd0, grant_id_o, fifo_data_o}, {22'd0, mon_e});
        chk("beat_grant", {28'd0, grant_o}, 32'd1 << mon_e[GW+DW-1:DW]);
      end
    end
  end

  task automatic refresh();
    for (int r = 0; r < NR; r++) begin
      if (src_q[r].size() > 0) begin
        req_valid_i[r]         = 1'b1;
        req_data_i[r*DW +: DW] = src_q[r][0][7:0];
        req_last_i[r]          = src_q[r][0][8];
      end else begin
        req_valid_i[r]         = 1'b0;
        req_data_i[r*DW +: DW] = '0;
        req_last_i[r]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [8:0] dummy;
    @(posedge clk_i);
    #1;
    for (int r = 0; r < NR; r++) if (hs_r[r]) dummy = src_q[r].pop_front();
    refresh();
  endtask

  task automatic push(input int r, input int d, input logic last);
    logic [31:0] dv;
    dv = d;
    src_q[r].push_back({last, dv[7:0]});
  endtask

  task automatic expb(input int id, input int d);
    logic [31:0] iv, dv;
    iv = id;
    dv = d;
    exp_q.push_back({iv[GW-1:0], dv[7:0]});
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (bc_q.size() < n && k < budget) begin step(); k++; end
    if (bc_q.size() < n) begin
      n_chk++;
      $display("FAIL wait_beats: got %0d beats, required %0d", bc_q.size(), n);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin step(); k++; end
    chk("drain_left", exp_q.size(), 0);
    step();
    step();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    bc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_i       = 1'b1;
    fifo_wready_i = 1'b0;
    req_valid_i   = '0;
    req_data_i    = '0;
    req_last_i    = '0;

    // 1: reset with all requesters valid, then first grant goes to req 0
    for (int r = 0; r < NR; r++) push(r, 'hA0 + r, 1'b0);
    refresh();
    step();
    @(negedge clk_i);
    chk("reset_outs", {12'd0, req_ready_o, fifo_wvalid_o, fifo_data_o, grant_o, grant_id_o, busy_o}, 0);
    step();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_idle", {12'd0, req_ready_o, fifo_wvalid_o, fifo_data_o, grant_o, grant_id_o, busy_o}, 0);
    step();
    @(negedge clk_i);
    chk("first_grant", grant_o, 4'b0001);
    chk("first_grant_id", grant_id_o, 0);
    chk("first_busy", busy_o, 1);
    chk("full_ready", req_ready_o, 0);
    chk("full_wvalid", fifo_wvalid_o, 1);
    chk("full_data", fifo_data_o, 'hA0);
    do_reset();
    for (int r = 0; r < NR; r++) src_q[r].delete();
    refresh();

    // 2: single requester, burst split by the MaxBurst limit
    fifo_wready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin push(1, 'h10 + i, 1'b0); expb(1, 'h10 + i); end
    refresh();
    drain(60);
    chk("t2_nbeats", bc_q.size(), 6);
    if (bc_q.size() >= 6) begin
      chk("t2_burst_span", bc_q[3] - bc_q[0], 3);
      chk("t2_idle_gap", bc_q[4] - bc_q[3], 2);
      chk("t2_tail", bc_q[5] - bc_q[4], 1);
    end

    // 3: all requesters busy, grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 8; i++) push(0, 'h30 + i, 1'b0);
    for (int r = 1; r < NR; r++)
      for (int i = 0; i < 4; i++) push(r, 'h30 + 16*r + i, 1'b0);
    for (int i = 0; i < 4; i++) expb(0, 'h30 + i);
    for (int r = 1; r < NR; r++)
      for (int i = 0; i < 4; i++) expb(r, 'h30 + 16*r + i);
    for (int i = 4; i < 8; i++) expb(0, 'h30 + i);
    refresh();
    drain(200);
    chk("t3_nbeats", bc_q.size(), 20);
    if (bc_q.size() >= 20) begin
      for (int g = 0; g < 5; g++) chk("t3_burst_span", bc_q[4*g+3] - bc_q[4*g], 3);
      for (int g = 0; g < 4; g++) chk("t3_idle_gap", bc_q[4*g+4] - bc_q[4*g+3], 2);
    end

    // 4: FIFO full for 3 cycles after the 2nd beat of req 2
    do_reset();
    for (int i = 0; i < 6; i++) begin push(2, 'h70 + i, 1'b0); expb(2, 'h70 + i); end
    refresh();
    wait_beats(2, 20);
    fifo_wready_i = 1'b0;
    @(negedge clk_i);
    chk("t4_stall_ready", req_ready_o, 0);
    chk("t4_stall_grant", grant_o, 4'b0100);
    chk("t4_stall_data", fifo_data_o, 'h72);
    chk("t4_stall_wvalid", fifo_wvalid_o, 1);
    step();
    step();
    step();
    fifo_wready_i = 1'b1;
    drain(40);
    chk("t4_nbeats", bc_q.size(), 6);
    if (bc_q.size() >= 6) begin
      chk("t4_stall_len", bc_q[2] - bc_q[1], 4);
      chk("t4_resume", bc_q[3] - bc_q[2], 1);
      chk("t4_burst_end", bc_q[4] - bc_q[3], 2);
    end

    // 5: req 0 drops valid after 2 beats
    do_reset();
`ifdef FIFO_ARB_PKT_LOCK_EN
    for (int i = 0; i < 7; i++) expb(0, 'h80 + i);
    expb(1, 'h90);
`else
    expb(0, 'h80);
    expb(0, 'h81);
    expb(1, 'h90);
    for (int i = 2; i < 7; i++) expb(0, 'h80 + i);
`endif
    push(0, 'h80, 1'b0);
    push(0, 'h81, 1'b0);
    push(1, 'h90, 1'b1);
    refresh();
    wait_beats(2, 20);
    step();
    step();
    step();
    for (int i = 2; i < 7; i++) push(0, 'h80 + i, i == 6);
    refresh();
    drain(80);
    if (bc_q.size() >= 3) begin
`ifdef FIFO_ARB_PKT_LOCK_EN
      chk("t5_hold_gap", bc_q[2] - bc_q[1], 4);
`else
      chk("t5_regrant_gap", bc_q[2] - bc_q[1], 3);
`endif
    end else begin
      n_chk++;
      $display("FAIL t5_nbeats: got %0d beats, required at least 3", bc_q.size());
    end

    // 6: reset pulsed during the 3rd beat of a req 3 burst
    do_reset();
    expb(3, 'hB0);
    expb(3, 'hB1);
    expb(0, 'hC0);
    for (int i = 2; i < 6; i++) expb(3, 'hB0 + i);
    for (int i = 0; i < 6; i++) push(3, 'hB0 + i, 1'b0);
    refresh();
    wait_beats(2, 20);
    reset_i = 1'b1;
    push(0, 'hC0, 1'b1);
    refresh();
    @(negedge clk_i);
    chk("t6_rst_wvalid", fifo_wvalid_o, 0);
    chk("t6_rst_ready", req_ready_o, 0);
    step();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("t6_idle_grant", grant_o, 0);
    chk("t6_idle_busy", busy_o, 0);
    step();
    @(negedge clk_i);
    chk("t6_regrant_req0", grant_o, 4'b0001);
    drain(60);

    for (int r = 0; r < NR; r++) chk("src_empty", src_q[r].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
